// File: rtl/int_to_bf16_pipe.sv
// Multi-lane 3-stage signed-integer to BF16 converter with valid/ready handshake.
// Define INT2BF16_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module int_to_bf16_pipe #(
    parameter int IN_W  = 24,
    parameter int LANES = 2,
    parameter int CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [LANES*IN_W-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [LANES*16-1:0]   out_data_o,
    output logic [LANES-1:0]      out_inexact_o,
    output logic [CNT_W-1:0]      beat_cnt_o
);

    // Normalised magnitude extended with zeros so guard/sticky always exist.
    localparam int XW = IN_W + 9;

    logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [LANES-1:0]      sign1_q, sign1_d;
    logic [LANES*IN_W-1:0] mag1_q, mag1_d;
    logic [LANES-1:0]      sign2_q, sign2_d;
    logic [LANES-1:0]      zero2_q, zero2_d;
    logic [LANES*8-1:0]    exp2_q, exp2_d;
    logic [LANES*IN_W-1:0] norm2_q, norm2_d;
    logic [LANES*16-1:0]   data3_q, data3_d;
    logic [LANES-1:0]      inex3_q, inex3_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic load2, load3, in_ready, accept;

    always_comb begin
        logic [IN_W-1:0] x, m;
        logic [XW-1:0]   nx;
        logic [6:0]      mant;
        logic [7:0]      rnd;
        logic            g, st, inc;
        int              p;

        x    = '0;
        m    = '0;
        nx   = '0;
        mant = '0;
        rnd  = '0;
        g    = 1'b0;
        st   = 1'b0;
        inc  = 1'b0;
        p    = 0;

        load3    = !v3_q || out_ready_i;
        load2    = !v2_q || load3;
        in_ready = (!v1_q || load2) && !flush_i;
        accept   = in_valid_i && in_ready;

        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        sign1_d = sign1_q;
        mag1_d  = mag1_q;
        sign2_d = sign2_q;
        zero2_d = zero2_q;
        exp2_d  = exp2_q;
        norm2_d = norm2_q;
        data3_d = data3_q;
        inex3_d = inex3_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, accept};

        if (flush_i) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end else begin
            if (!v1_q || load2) v1_d = in_valid_i;
            if (load2)          v2_d = v1_q;
            if (load3)          v3_d = v2_q;
        end

        // S1: sign and unsigned magnitude; the most negative input maps to 2^(IN_W-1).
        if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                x = in_data_i[k*IN_W +: IN_W];
                sign1_d[k] = x[IN_W-1];
                mag1_d[k*IN_W +: IN_W] = x[IN_W-1] ? (~x + 1'b1) : x;
            end
        end

        // S2: leading-one detect and left-normalise so the leading one sits at the MSB.
        if (load2 && v1_q && !flush_i) begin
            for (int k = 0; k < LANES; k++) begin
                m = mag1_q[k*IN_W +: IN_W];
                p = 0;
                for (int i = 0; i < IN_W; i++) begin
                    if (m[i]) p = i;
                end
                sign2_d[k] = sign1_q[k];
                zero2_d[k] = (m == '0);
                exp2_d[k*8 +: 8] = 8'(127 + p);
                norm2_d[k*IN_W +: IN_W] = m << (IN_W - 1 - p);
            end
        end

        // S3: extract mantissa/guard/sticky, round, pack.
        if (load3 && v2_q && !flush_i) begin
            for (int k = 0; k < LANES; k++) begin
                nx   = {norm2_q[k*IN_W +: IN_W], 9'b0};
                mant = nx[XW-2 -: 7];
                g    = nx[XW-9];
                st   = |nx[XW-10:0];
`ifdef INT2BF16_RNE_EN
                inc  = g && (st || mant[0]);
`else
                inc  = 1'b0;
`endif
                rnd  = {1'b0, mant} + {7'b0, inc};
                if (zero2_q[k]) begin
                    data3_d[k*16 +: 16] = 16'h0000;
                    inex3_d[k]          = 1'b0;
                end else begin
                    // A carry out of the mantissa leaves rnd[6:0] at zero and bumps the exponent.
                    data3_d[k*16 +: 16] = {sign2_q[k], exp2_q[k*8 +: 8] + {7'b0, rnd[7]}, rnd[6:0]};
                    inex3_d[k]          = g || st;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            sign1_q <= '0;
            mag1_q  <= '0;
            sign2_q <= '0;
            zero2_q <= '0;
            exp2_q  <= '0;
            norm2_q <= '0;
            data3_q <= '0;
            inex3_q <= '0;
            cnt_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            sign1_q <= sign1_d;
            mag1_q  <= mag1_d;
            sign2_q <= sign2_d;
            zero2_q <= zero2_d;
            exp2_q  <= exp2_d;
            norm2_q <= norm2_d;
            data3_q <= data3_d;
            inex3_q <= inex3_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o    = in_ready;
    assign out_valid_o   = v3_q;
    assign out_data_o    = data3_q;
    assign out_inexact_o = inex3_q;
    assign beat_cnt_o    = cnt_q;

endmodule

// File: tb/tb_int_to_bf16_pipe.sv
// Scoreboard bench for int_to_bf16_pipe (IN_W=24, LANES=2); follows INT2BF16_RNE_EN if defined.
module tb_int_to_bf16_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [47:0] in_data_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_data_o;
    logic [1:0]  out_inexact_o;
    logic [31:0] beat_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int exp_cnt = 0;
    int rdy_mode = 0;         // 0: always ready, 1: random, 2: never ready
    logic [33:0] sb_q[$];     // {inexact[1:0], data[31:0]}

    always #5 clk_i = ~clk_i;

    int_to_bf16_pipe #(.IN_W(24), .LANES(2), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_inexact_o(out_inexact_o), .beat_cnt_o(beat_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference converter: returns {inexact, bf16}.
    function automatic logic [16:0] model(input int v);
        longint m;
        int     p, e, mant;
        logic   g, st;
        if (v == 0) return 17'h0;
        m = (v < 0) ? -longint'(v) : longint'(v);
        p = 0;
        for (int i = 0; i < 40; i++) if (((m >> i) & 1) != 0) p = i;
        e = 127 + p;
        if (p >= 8) begin
            mant = int'((m >> (p - 7)) & 127);
            g    = ((m >> (p - 8)) & 1) != 0;
            st   = (p > 8) ? ((m & ((longint'(1) << (p - 8)) - 1)) != 0) : 1'b0;
        end else begin
            mant = int'((m << (7 - p)) & 127);
            g    = 1'b0;
            st   = 1'b0;
        end
`ifdef INT2BF16_RNE_EN
        if (g && (st || (mant % 2 == 1))) mant++;
        if (mant == 128) begin mant = 0; e++; end
`endif
        return {g | st, (v < 0), 8'(e), 7'(mant)};
    endfunction

    initial forever begin
        @(negedge clk_i);
        case (rdy_mode)
            0: out_ready_i = 1'b1;
            1: out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = 1'b0;
        endcase
    end

    // Output monitor: pops scoreboard on each transfer, checks stability while stalled.
    initial begin
        logic        hold_v;
        logic [33:0] hold_d, e;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk_i);
            #2;
            if (hold_v) begin
                chk("stall_valid", 64'(out_valid_o), 64'd1);
                chk("stall_data", 64'({out_inexact_o, out_data_o}), 64'(hold_d));
            end
            hold_v = 1'b0;
            if (out_valid_o && out_ready_i) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_out", 64'(out_data_o), 64'hDEAD);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", 64'(out_data_o), 64'(e[31:0]));
                    chk("out_inexact", 64'(out_inexact_o), 64'(e[33:32]));
                end
            end else if (out_valid_o) begin
                hold_v = 1'b1;
                hold_d = {out_inexact_o, out_data_o};
            end
            if (flush_i || !rst_ni) hold_v = 1'b0;
        end
    end

    task automatic send_exp(input logic [23:0] a, input logic [23:0] b,
                            input logic [31:0] ed, input logic [1:0] ei);
        int guard;
        @(negedge clk_i);
        in_valid_i = 1'b1;
        in_data_i  = {b, a};
        #1;
        guard = 0;
        while (!in_ready_o && guard < 200) begin
            @(negedge clk_i);
            #1;
            guard++;
        end
        if (!in_ready_o) begin
            chk("accept_timeout", 64'(in_ready_o), 64'd1);
            in_valid_i = 1'b0;
        end else begin
            sb_q.push_back({ei, ed});
            exp_cnt++;
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
        end
    endtask

    task automatic send(input int a, input int b);
        logic [16:0] ma, mb;
        ma = model(a);
        mb = model(b);
        send_exp(24'(a), 24'(b), {mb[15:0], ma[15:0]}, {mb[16], ma[16]});
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((sb_q.size() != 0 || out_valid_o) && i < 500) begin
            @(negedge clk_i);
            #3;
            i++;
        end
        chk("drain_left", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int lat, snap;
        logic signed [23:0] r;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_data", 64'(out_data_o), 64'd0);
        chk("rst_inexact", 64'(out_inexact_o), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);

        // 1) +/-1 and latency from the accepting edge
        send_exp(24'd1, 24'hFFFFFF, {16'hBF80, 16'h3F80}, 2'b00);
        lat = 1;
        while (!out_valid_o && lat < 10) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd3);
        drain();

        // 2) zero and most-negative input
        send_exp(24'd0, 24'h800000, {16'hCB00, 16'h0000}, 2'b00);
        // 3) rounding cases: ties, exact 8-bit value, carry out of mantissa
`ifdef INT2BF16_RNE_EN
        send_exp(24'd257, 24'd259, {16'h4382, 16'h4380}, 2'b11);
        send_exp(24'd255, 24'd511, {16'h4400, 16'h437F}, 2'b10);
`else
        send_exp(24'd257, 24'd259, {16'h4381, 16'h4380}, 2'b11);
        send_exp(24'd255, 24'd511, {16'h43FF, 16'h437F}, 2'b10);
`endif
        drain();
        chk("cnt_after_3", 64'(beat_cnt_o), 64'd4);

        // 4) back-to-back beats with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 20; i++) begin
            r = 24'($urandom);
            send(int'(r >>> $urandom_range(0, 23)), int'(-(r >>> $urandom_range(0, 23))));
        end
        drain();
        chk("cnt_after_20", 64'(beat_cnt_o), 64'(exp_cnt));

        // 5) flush with three beats in flight
        rdy_mode = 2;
        repeat (2) @(negedge clk_i);
        snap = n_out;
        send(3, -3);
        send(100, -100);
        send(70000, -70000);
        @(negedge clk_i);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = {24'd5, 24'd5};
        #1;
        chk("flush_in_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        sb_q.delete();
        chk("flush_out_valid", 64'(out_valid_o), 64'd0);
        chk("flush_beat_cnt", 64'(beat_cnt_o), 64'(exp_cnt));
        rdy_mode = 0;
        repeat (5) @(negedge clk_i);
        chk("flush_no_out", 64'(n_out), 64'(snap));
        send(-12345, 6);
        drain();
        chk("post_flush_out", 64'(n_out), 64'(snap + 1));

        // 6) reset with a full pipe
        rdy_mode = 2;
        repeat (2) @(negedge clk_i);
        send(7, 8);
        send(9, 10);
        send(11, 12);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        sb_q.delete();
        exp_cnt = 0;
        chk("mrst_out_valid", 64'(out_valid_o), 64'd0);
        chk("mrst_out_data", 64'(out_data_o), 64'd0);
        chk("mrst_inexact", 64'(out_inexact_o), 64'd0);
        chk("mrst_beat_cnt", 64'(beat_cnt_o), 64'd0);
        chk("mrst_in_ready", 64'(in_ready_o), 64'd1);
        rdy_mode = 0;
        send(-8388607, 8388607);
        drain();
        chk("mrst_cnt_after", 64'(beat_cnt_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
